// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: datapath width,
// ALU control codes from the ALU decoder, divider FSM states and a small
// magnitude helper used when latching signed divide operands.
package hilo_mdu_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 5;

   // Control codes produced by the ALU decoder for the E-stage instruction.
   localparam logic [4:0] SIG_ALU_FAIL  = 5'b00000;
   localparam logic [4:0] SIG_ALU_MULT  = 5'b10000;
   localparam logic [4:0] SIG_ALU_MULTU = 5'b10001;
   localparam logic [4:0] SIG_ALU_DIV   = 5'b10010;
   localparam logic [4:0] SIG_ALU_DIVU  = 5'b10011;
   localparam logic [4:0] SIG_ALU_MFHI  = 5'b10100;
   localparam logic [4:0] SIG_ALU_MFLO  = 5'b10101;

   // Divider sequencing: IDLE waits for a start, RUN performs one restoring
   // step per cycle, DONE presents the sign-corrected result for one cycle.
   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_RUN  = 2'b01,
      DIV_DONE = 2'b10
   } divState_t;

   // Two's-complement magnitude when the operand is treated as signed;
   // 0x80000000 maps to itself, which is the correct unsigned magnitude.
   function automatic logic [DATA_W-1:0] absVal(input logic [DATA_W-1:0] v,
                                                input logic               isSigned);
      return (isSigned && v[DATA_W-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/hilo_mdu_div_radix2.sv
// Iterative radix-2 restoring divider. Operands are latched on start as
// magnitudes plus sign flags, 32 restoring steps run one per cycle, and the
// signed/zero-divisor corrected quotient and remainder are valid while done
// is high. An abort during RUN drops the operation without producing a result.
module div_radix2
   import hilo_mdu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [DATA_W-1:0] i_dividend,
   input  logic [DATA_W-1:0] i_divisor,
   input  logic              i_signed,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_quotient,
   output logic [DATA_W-1:0] o_remainder
);

   divState_t         r_state;
   divState_t         w_stateNext;
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_quo;
   logic [DATA_W-1:0] r_divisor;
   logic [DATA_W-1:0] r_dividendRaw;
   logic              r_negQuo;
   logic              r_negRem;
   logic              r_divZero;

   logic [DATA_W:0]   w_shifted;
   logic [DATA_W:0]   w_trial;
   logic              w_fits;

   // One restoring step: bring the next dividend bit into the partial
   // remainder and see whether the divisor can be taken out of it.
   assign w_shifted = {r_rem, r_quo[DATA_W-1]};
   assign w_trial   = w_shifted - {1'b0, r_divisor};
   assign w_fits    = ~w_trial[DATA_W];

   // State register for the divide sequencer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= DIV_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state logic; starts are only honoured from IDLE and an abort only
   // matters while iterating, since DONE always falls back to IDLE anyway.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         DIV_IDLE: begin
            if (i_start) begin
               w_stateNext = DIV_RUN;
            end
         end
         DIV_RUN: begin
            if (i_abort) begin
               w_stateNext = DIV_IDLE;
            end else if (r_count == {CNT_W{1'b1}}) begin
               w_stateNext = DIV_DONE;
            end
         end
         DIV_DONE: begin
            w_stateNext = DIV_IDLE;
         end
         default: begin
            w_stateNext = DIV_IDLE;
         end
      endcase
   end

   // Operand capture on start and the shift/subtract datapath during RUN.
   // The quotient register starts out holding the dividend magnitude and
   // its bits are replaced by quotient bits as they shift out the top.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count       <= '0;
         r_rem         <= '0;
         r_quo         <= '0;
         r_divisor     <= '0;
         r_dividendRaw <= '0;
         r_negQuo      <= 1'b0;
         r_negRem      <= 1'b0;
         r_divZero     <= 1'b0;
      end else begin
         case (r_state)
            DIV_IDLE: begin
               if (i_start) begin
                  r_count       <= '0;
                  r_rem         <= '0;
                  r_quo         <= absVal(i_dividend, i_signed);
                  r_divisor     <= absVal(i_divisor, i_signed);
                  r_dividendRaw <= i_dividend;
                  r_negQuo      <= i_signed & (i_dividend[DATA_W-1] ^ i_divisor[DATA_W-1]);
                  r_negRem      <= i_signed & i_dividend[DATA_W-1];
                  r_divZero     <= (i_divisor == '0);
               end
            end
            DIV_RUN: begin
               if (!i_abort) begin
                  r_count <= r_count + 1'b1;
                  r_rem   <= w_fits ? w_trial[DATA_W-1:0] : w_shifted[DATA_W-1:0];
                  r_quo   <= {r_quo[DATA_W-2:0], w_fits};
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Result shaping: a zero divisor returns the raw dividend in the
   // remainder and all ones in the quotient with no sign fix-up; otherwise
   // the quotient takes sign sa^sb and the remainder follows the dividend.
   always_comb begin
      o_quotient  = r_negQuo ? (~r_quo + 1'b1) : r_quo;
      o_remainder = r_negRem ? (~r_rem + 1'b1) : r_rem;
      if (r_divZero) begin
         o_quotient  = {DATA_W{1'b1}};
         o_remainder = r_dividendRaw;
      end
   end

   assign o_busy = (r_state == DIV_RUN);
   assign o_done = (r_state == DIV_DONE);

endmodule

// File: rtl/hilo_mdu.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO
// registers. Multiplies write HI/LO at the end of their E cycle, divides
// stall the front of the pipeline while the iterative divider runs, and
// MFHI/MFLO read the current HI/LO combinationally.
module hilo_mdu
   import hilo_mdu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic [4:0]        alucontrol_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              flush_i,
   output logic              stall_o,
   output logic [DATA_W-1:0] result_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   logic [DATA_W-1:0]   r_hi;
   logic [DATA_W-1:0]   r_lo;

   logic                w_isMult;
   logic                w_isMultu;
   logic                w_isDiv;
   logic                w_isDivu;
   logic                w_issue;
   logic                w_mulStart;
   logic                w_divStart;
   logic                w_divBusy;
   logic                w_divDone;
   logic                w_divIdle;
   logic [DATA_W-1:0]   w_quotient;
   logic [DATA_W-1:0]   w_remainder;
   logic [2*DATA_W-1:0] w_prodSigned;
   logic [2*DATA_W-1:0] w_prodUnsigned;

   // Decode the E-stage operation. A flushed or bubble slot never starts
   // anything, and a multiply is only accepted while no divide owns E.
   assign w_isMult   = (alucontrol_i == SIG_ALU_MULT);
   assign w_isMultu  = (alucontrol_i == SIG_ALU_MULTU);
   assign w_isDiv    = (alucontrol_i == SIG_ALU_DIV);
   assign w_isDivu   = (alucontrol_i == SIG_ALU_DIVU);
   assign w_issue    = en_i & ~flush_i;
   assign w_divIdle  = ~w_divBusy & ~w_divDone;
   assign w_mulStart = w_issue & w_divIdle & (w_isMult | w_isMultu);
   assign w_divStart = w_issue & (w_isDiv | w_isDivu);

   // Single-cycle 64-bit products; operands are widened explicitly so the
   // signed form sees proper sign extension.
   assign w_prodSigned   = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) *
                           $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
   assign w_prodUnsigned = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

   div_radix2 u_div (
      .clk         (clk),
      .rst         (rst),
      .i_start     (w_divStart),
      .i_abort     (flush_i),
      .i_dividend  (a_i),
      .i_divisor   (b_i),
      .i_signed    (w_isDiv),
      .o_busy      (w_divBusy),
      .o_done      (w_divDone),
      .o_quotient  (w_quotient),
      .o_remainder (w_remainder)
   );

   // Hold the front of the pipeline from the start cycle through the last
   // iteration; a flush releases the stall in the very cycle it arrives.
   assign stall_o = (w_divIdle & w_divStart) | (w_divBusy & ~flush_i);

   // HI/LO write port: a finishing divide has priority, then a multiply
   // start; a flush in that cycle cancels either write.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_divDone && !flush_i) begin
         r_hi <= w_remainder;
         r_lo <= w_quotient;
      end else if (w_mulStart) begin
         {r_hi, r_lo} <= w_isMult ? w_prodSigned : w_prodUnsigned;
      end
   end

   // Move-from read path; every other code returns zero.
   always_comb begin
      result_o = '0;
      if (alucontrol_i == SIG_ALU_MFHI) begin
         result_o = r_hi;
      end else if (alucontrol_i == SIG_ALU_MFLO) begin
         result_o = r_lo;
      end
   end

   assign hi_o = r_hi;
   assign lo_o = r_lo;

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: directed cases for multiply, divide,
// zero divisor, overflow, flush and reset, followed by random operations,
// all compared against an arithmetic reference model of HI/LO.
module tb_hilo_mdu;
   import hilo_mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [4:0]  alu;
   logic [31:0] aIn;
   logic [31:0] bIn;
   logic        flush;
   logic        stall;
   logic [31:0] result;
   logic [31:0] hiOut;
   logic [31:0] loOut;

   int          nCompared   = 0;
   int          nMismatched = 0;
   logic [31:0] hiM = '0;
   logic [31:0] loM = '0;

   hilo_mdu dut (
      .clk          (clk),
      .rst          (rst),
      .en_i         (en),
      .alucontrol_i (alu),
      .a_i          (aIn),
      .b_i          (bIn),
      .flush_i      (flush),
      .stall_o      (stall),
      .result_o     (result),
      .hi_o         (hiOut),
      .lo_o         (loOut)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Advance one clock and land just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp)
      else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Architectural meaning of each HI/LO-writing operation: {HI, LO}.
   function automatic logic [63:0] refHiLo(input logic [4:0] code, input logic [31:0] a,
                                           input logic [31:0] b);
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      longint          sq;
      longint          sr;
      logic   [63:0]   res;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      res = '0;
      if (code == SIG_ALU_MULT) begin
         res = sa * sb;
      end else if (code == SIG_ALU_MULTU) begin
         res = ua * ub;
      end else if (b == 32'd0) begin
         res = {a, 32'hFFFF_FFFF};
      end else if (code == SIG_ALU_DIV) begin
         sq  = sa / sb;
         sr  = sa % sb;
         res = {sr[31:0], sq[31:0]};
      end else begin
         res = {32'(ua % ub), 32'(ua / ub)};
      end
      return res;
   endfunction

   // Compare the visible HI/LO and both move-from reads against the model.
   task automatic checkHiLo(input string tag);
      checkOutput({tag, ".hi"}, hiOut, hiM);
      checkOutput({tag, ".lo"}, loOut, loM);
      alu = SIG_ALU_MFHI;
      #1;
      checkOutput({tag, ".mfhi"}, result, hiM);
      alu = SIG_ALU_MFLO;
      #1;
      checkOutput({tag, ".mflo"}, result, loM);
      alu = SIG_ALU_FAIL;
   endtask

   // Issue one MULT/MULTU/DIV/DIVU in E. For divides, operands and the code
   // are scrambled during RUN, stall cycles are counted against a bound, and
   // flushLast cancels the write in the final (DONE or MULT) cycle.
   task automatic applyStimulus(input string tag, input logic [4:0] code, input logic [31:0] a,
                                input logic [31:0] b, input logic flushLast);
      int          stalls;
      logic [63:0] exp;
      exp = refHiLo(code, a, b);
      en  = 1'b1;
      alu = code;
      aIn = a;
      bIn = b;
      flush = 1'b0;
      #1;
      if (code == SIG_ALU_MULT || code == SIG_ALU_MULTU) begin
         checkOutput({tag, ".mulStall"}, {31'd0, stall}, 32'd0);
         flush = flushLast;
         #1;
      end else begin
         stalls = 0;
         while (stall === 1'b1 && stalls < 40) begin
            stalls++;
            tick();
            aIn = $urandom;
            bIn = $urandom;
            alu = ($urandom_range(0, 1) == 0) ? SIG_ALU_MULT : code;
            #1;
         end
         checkOutput({tag, ".stallCycles"}, stalls, 32'd33);
         alu   = code;
         flush = flushLast;
         #1;
      end
      tick();
      flush = 1'b0;
      en    = 1'b0;
      alu   = SIG_ALU_FAIL;
      if (!flushLast) begin
         {hiM, loM} = exp;
      end
      #1;
      checkOutput({tag, ".stallAfter"}, {31'd0, stall}, 32'd0);
      checkHiLo(tag);
   endtask

   initial begin
      logic [4:0]  code;
      logic [31:0] ra;
      logic [31:0] rb;

      // Reset with a move-from code present: everything must read zero.
      rst   = 1'b1;
      en    = 1'b0;
      alu   = SIG_ALU_MFHI;
      aIn   = '0;
      bIn   = '0;
      flush = 1'b0;
      tick();
      tick();
      checkOutput("reset.hi", hiOut, 32'd0);
      checkOutput("reset.lo", loOut, 32'd0);
      checkOutput("reset.stall", {31'd0, stall}, 32'd0);
      checkOutput("reset.result", result, 32'd0);
      rst = 1'b0;
      alu = SIG_ALU_FAIL;
      tick();

      // Multiplies, then a MFHI in the cycle right after the MULT.
      applyStimulus("multNeg", SIG_ALU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
      applyStimulus("multuMax", SIG_ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

      // Directed divides including zero divisor and signed overflow.
      applyStimulus("divNeg", SIG_ALU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      applyStimulus("divu100by7", SIG_ALU_DIVU, 32'd100, 32'd7, 1'b0);
      applyStimulus("divuByZero", SIG_ALU_DIVU, 32'd5, 32'd0, 1'b0);
      applyStimulus("divOverflow", SIG_ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      applyStimulus("divNegByZero", SIG_ALU_DIV, 32'hFFFF_FFF0, 32'd0, 1'b0);

      // Divide code in a bubble slot does not start anything.
      en  = 1'b0;
      alu = SIG_ALU_DIV;
      aIn = 32'd77;
      bIn = 32'd5;
      #1;
      checkOutput("bubbleDiv.stall", {31'd0, stall}, 32'd0);
      tick();
      checkOutput("bubbleDiv.stallNext", {31'd0, stall}, 32'd0);
      checkHiLo("bubbleDiv");

      // Flushed multiply and flushed DONE cycle leave HI/LO untouched.
      applyStimulus("multFlushed", SIG_ALU_MULT, 32'd1234, 32'd5678, 1'b1);
      applyStimulus("divDoneFlushed", SIG_ALU_DIV, 32'd1000, 32'd3, 1'b1);

      // Flush in RUN cycle 10: stall drops at once and no write ever lands.
      en  = 1'b1;
      alu = SIG_ALU_DIV;
      aIn = 32'd50;
      bIn = 32'd6;
      #1;
      checkOutput("flushRun.startStall", {31'd0, stall}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
      end
      flush = 1'b1;
      #1;
      checkOutput("flushRun.stallNow", {31'd0, stall}, 32'd0);
      tick();
      flush = 1'b0;
      en    = 1'b0;
      alu   = SIG_ALU_FAIL;
      for (int i = 0; i < 30; i++) begin
         tick();
      end
      checkOutput("flushRun.stallLater", {31'd0, stall}, 32'd0);
      checkHiLo("flushRun");
      applyStimulus("div9by3", SIG_ALU_DIV, 32'd9, 32'd3, 1'b0);

      // Reset in the middle of a divide, then MULT followed by MFHI.
      en  = 1'b1;
      alu = SIG_ALU_DIVU;
      aIn = 32'd999;
      bIn = 32'd4;
      for (int i = 0; i < 6; i++) begin
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      en  = 1'b0;
      alu = SIG_ALU_FAIL;
      hiM = '0;
      loM = '0;
      #1;
      checkOutput("resetRun.stall", {31'd0, stall}, 32'd0);
      checkHiLo("resetRun");
      applyStimulus("multAfterReset", SIG_ALU_MULT, 32'h0001_0000, 32'hFFFF_0000, 1'b0);

      // Random operations against the reference model.
      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 3))
            0:       code = SIG_ALU_MULT;
            1:       code = SIG_ALU_MULTU;
            2:       code = SIG_ALU_DIV;
            default: code = SIG_ALU_DIVU;
         endcase
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 5) == 0) begin
            rb = 32'd0;
         end else if ($urandom_range(0, 2) == 0) begin
            rb = $urandom_range(1, 300);
            if ($urandom_range(0, 1) == 0) begin
               rb = -rb;
            end
         end
         applyStimulus($sformatf("rand%0d", n), code, ra, rb, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
